// File: rtl/spi_peripheral_sampled.sv
// SPI peripheral, all pins resampled into i_clock. Pin-to-effect latency is SYNC_STAGES+1 clocks.
// No backpressure toward the controller: an unconsumed rx byte is overwritten, and an empty tx buffer sends TX_IDLE_BYTE.
`timescale 1ns/1ps
module spi_peripheral_sampled #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_mode,
  input  logic       i_sclk,
  input  logic       i_pico,
  input  logic       i_cs,
  output logic       o_poci,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_rx_overrun,
  output logic       o_tx_underrun
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_pico_sync;
  logic                   r_sclk_d;
  state_t                 r_state;
  logic                   r_armed;
  logic [1:0]             r_mode;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_txbuf;
  logic                   r_txbuf_full;
  logic                   r_skip;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_pico_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_pico_sync <= {r_pico_sync[SYNC_STAGES-2:0], i_pico};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_cs, w_pico, w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
  logic w_entry, w_byte_done, w_load, w_tx_hs, w_rx_hs;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_pico      = r_pico_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_lead      = r_mode[1] ? w_fall : w_rise;
  assign w_trail     = r_mode[1] ? w_rise : w_fall;
  assign w_sample    = r_mode[0] ? w_trail : w_lead;
  assign w_shift     = r_mode[0] ? w_lead : w_trail;
  assign w_entry     = (r_state == S_IDLE) && r_armed && !w_cs;
  assign w_byte_done = (r_state == S_ACTIVE) && !w_cs && w_sample && (r_bit_cnt == 3'd7);
  assign w_load      = w_entry | w_byte_done;
  assign w_tx_hs     = i_tx_valid & ~r_txbuf_full;
  assign w_rx_hs     = o_rx_valid & i_rx_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_mode        <= 2'b00;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 8'h00;
      o_rx_data     <= 8'h00;
      o_rx_valid    <= 1'b0;
      r_txbuf       <= 8'h00;
      r_txbuf_full  <= 1'b0;
      r_tx_shift    <= TX_IDLE_BYTE;
      r_skip        <= 1'b0;
      o_rx_overrun  <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_rx_overrun  <= 1'b0;
      o_tx_underrun <= 1'b0;
      if (w_rx_hs) o_rx_valid <= 1'b0;
      if (w_load) begin
        if (r_txbuf_full) begin
          r_tx_shift   <= r_txbuf;
          r_txbuf_full <= 1'b0;
        end else begin
          r_tx_shift    <= TX_IDLE_BYTE;
          o_tx_underrun <= 1'b1;
        end
      end
      if (w_tx_hs) begin
        r_txbuf      <= i_tx_data;
        r_txbuf_full <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // Arming requires cs seen high after reset, so a reset inside a held-low cs cannot restart mid-byte.
          if (w_cs) r_armed <= 1'b1;
          if (w_entry) begin
            r_state    <= S_ACTIVE;
            r_mode     <= i_mode;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_skip     <= i_mode[0];
          end
        end
        S_ACTIVE: begin
          if (w_cs) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
          end else begin
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[6:0], w_pico};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                o_rx_data    <= {r_rx_shift[6:0], w_pico};
                o_rx_valid   <= 1'b1;
                o_rx_overrun <= o_rx_valid & ~i_rx_ready;
                // The freshly loaded byte already shows bit 7; the next shift edge must not advance it.
                r_skip       <= 1'b1;
              end
            end
            if (w_shift) begin
              if (r_skip) r_skip <= 1'b0;
              else        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_ready = ~r_txbuf_full;
  assign o_poci     = i_cs ? 1'bz : r_tx_shift[7];

endmodule

// File: doc/spi_peripheral_sampled.md
SPI_PERIPHERAL_SAMPLED -- requirements
Module: spi_peripheral_sampled

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk, cs and pico (legal range 2-4).
REQ-002 Parameter TX_IDLE_BYTE, default 8'hFF: byte shifted out when no transmit data is queued.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  2  {CPOL,CPHA}; sampled only on the idle-to-active transition.
REQ-006 sclk  input  1  SPI serial clock from the controller; asynchronous.
REQ-007 pico  input  1  controller-to-peripheral data; asynchronous.
REQ-008 cs  input  1  chip select, active-low; asynchronous.
REQ-009 poci  output  1  peripheral-to-controller data; high-Z when cs is high.
REQ-010 rx_data  output  8  last complete received byte.
REQ-011 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-012 rx_ready  input  1  consumer accepts rx_data on a cycle where rx_valid and rx_ready are both high.
REQ-013 tx_data  input  8  next byte to transmit.
REQ-014 tx_valid  input  1  tx_data is offered.
REQ-015 tx_ready  output  1  transmit buffer is empty; a byte is taken when tx_valid and tx_ready are both high.
REQ-016 rx_overrun  output  1  one-cycle pulse when a received byte overwrites an unconsumed byte.
REQ-017 tx_underrun  output  1  one-cycle pulse when TX_IDLE_BYTE is loaded because the buffer is empty.

Function
REQ-018 sclk, cs and pico shall each pass through SYNC_STAGES flops; all internal decisions use the synchronized copies only.
REQ-019 Edge detection shall compare the synchronized sclk with its one-cycle-delayed copy.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Trailing edge = the opposite edge.
REQ-020 Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1; shift edge = the other edge.
REQ-021 State machine has two states, IDLE and ACTIVE.
  - IDLE to ACTIVE on the first cycle synchronized cs is low: latch mode, clear the bit counter, load the shift register from the transmit buffer.
REQ-022 ACTIVE to IDLE on the first cycle synchronized cs is high: discard any partial byte (no rx_valid), clear the bit counter.
REQ-023 Bit order is MSB first for receive and transmit.
REQ-024 On each sample edge in ACTIVE: shift synchronized pico into rx_shift LSB; increment the 3-bit bit counter (wraps 7 to 0).
REQ-025 On the 8th sample edge (counter wraps): rx_data <= completed byte, rx_valid <= 1, in the same cycle.
REQ-026 rx_valid shall clear on an rx_ready handshake.
  - If a new byte completes in the same cycle as the handshake, rx_valid stays 1 with the new byte and rx_overrun does not pulse.
REQ-027 A byte completing while rx_valid=1 and rx_ready=0 shall overwrite rx_data and pulse rx_overrun.
REQ-028 Transmit bit presentation:
  - CPHA=0: bit 7 drives poci from ACTIVE entry; each shift edge advances one bit.
  - CPHA=1: the first shift edge of a byte presents bit 7; later shift edges advance one bit.
REQ-029 At each byte boundary (8th sample edge), the next shift-register byte shall be loaded:
  - from the transmit buffer if full (buffer empties, tx_ready rises next cycle);
  - else TX_IDLE_BYTE, with tx_underrun pulsing.
REQ-030 The ACTIVE-entry load follows the same buffer/underrun rule.
REQ-031 tx_ready = transmit buffer empty. A handshake and a boundary load in the same cycle shall load the buffered byte and accept the new byte into the buffer.
REQ-032 poci shall be 1'bZ whenever raw cs is high, otherwise the current transmit bit.
REQ-033 Throughput: clock shall be at least 4x sclk; latency from a pin edge to its effect is SYNC_STAGES+1 clocks.

Reset
REQ-034 On reset: state IDLE, bit counter 0, rx_shift 0, rx_data 8'h00, rx_valid 0, transmit buffer empty (tx_ready 1), shift register TX_IDLE_BYTE, rx_overrun 0, tx_underrun 0.
REQ-035 Reset asserted mid-byte shall abort the transfer with no rx_valid; after release the block waits for synchronized cs to go high then low before entering ACTIVE.

Verification
REQ-036 Mode 0, tx_data 8'hA5 queued, controller sends 8'h3C -> rx_data 8'h3C with rx_valid; controller reads 8'hA5; tx_ready re-asserts.
REQ-037 Modes 1, 2, 3, each with tx 8'h81 and rx 8'h7E -> correct bytes in both directions; no under/overrun.
REQ-038 Two back-to-back bytes 8'h11, 8'h22 with rx_ready held 0 -> rx_data 8'h22, one rx_overrun pulse, rx_valid stays 1.
REQ-039 No tx_valid, controller clocks 8 bits -> controller reads 8'hFF; tx_underrun pulses at entry and at the byte boundary.
REQ-040 cs raised after 5 bits, then a full byte 8'hC3 -> no rx_valid for the partial byte; next rx_data 8'hC3; poci Z while cs is high.
REQ-041 Reset pulsed after 3 bits with cs held low -> all outputs at reset values; no byte is captured until cs toggles high then low.
